// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, hazard/branch/interrupt inputs
// and the fetch/decode register fields.
interface fetch_unit_if;
  logic [31:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        int_req;
  logic        fd_enable;
  logic [4:0]  opcode;
  logic [2:0]  Rs;
  logic [2:0]  Rd;
  logic [4:0]  shmnt;
  logic [31:0] pc;
  logic [31:0] next_inst_addr;
  logic        int1;
  logic        int2;

  modport master (
    output imem_addr, fd_enable, opcode, Rs, Rd, shmnt, pc, next_inst_addr, int1, int2,
    input  imem_rdata, stall, branch_taken, branch_target, int_req
  );

  modport slave (
    input  imem_addr, fd_enable, opcode, Rs, Rd, shmnt, pc, next_inst_addr, int1, int2,
    output imem_rdata, stall, branch_taken, branch_target, int_req
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC ownership, boot from reset vector, branch/stall
// handling. Interrupt entry (INT1/INT2) is built only when FETCH_INTERRUPT_EN is defined.
module fetch_unit #(
  parameter logic [31:0] RESET_VEC_ADDR = 32'd0,
  parameter logic [31:0] INT_VEC_ADDR   = 32'd2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

`ifdef FETCH_INTERRUPT_EN
  typedef enum logic [2:0] {BOOT_HI, BOOT_LO, RUN, INT1, INT2} state_t;
`else
  typedef enum logic [1:0] {BOOT_HI, BOOT_LO, RUN} state_t;
`endif

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [15:0] vec_hi_reg;
  logic        take_int;

`ifdef FETCH_INTERRUPT_EN
  logic int_pending_reg;

  // A request in this very cycle is honoured immediately, so int_req in N gives INT1 in N+1.
  assign take_int = (state_reg == RUN) && (int_pending_reg || bus.int_req)
                    && !bus.stall && !bus.branch_taken;
`else
  logic unused_int_sink;
  assign take_int        = 1'b0;
  assign unused_int_sink = ^{bus.int_req, INT_VEC_ADDR};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= BOOT_HI;
      pc_reg     <= 32'd0;
      vec_hi_reg <= 16'd0;
`ifdef FETCH_INTERRUPT_EN
      int_pending_reg <= 1'b0;
`endif
    end else begin
`ifdef FETCH_INTERRUPT_EN
      if (take_int) begin
        int_pending_reg <= 1'b0;
      end else if (bus.int_req) begin
        int_pending_reg <= 1'b1;
      end
`endif
      case (state_reg)
        BOOT_HI: begin
          vec_hi_reg <= bus.imem_rdata;
          state_reg  <= BOOT_LO;
        end
        BOOT_LO: begin
          pc_reg    <= {vec_hi_reg, bus.imem_rdata};
          state_reg <= RUN;
        end
        RUN: begin
          if (bus.branch_taken) begin
            pc_reg <= bus.branch_target;
          end else if (take_int) begin
            state_reg <= state_t'(state_reg + 1'b1);
          end else if (!bus.stall) begin
            pc_reg <= pc_reg + 32'd1;
          end
        end
`ifdef FETCH_INTERRUPT_EN
        INT1: begin
          vec_hi_reg <= bus.imem_rdata;
          state_reg  <= INT2;
        end
        INT2: begin
          pc_reg    <= {vec_hi_reg, bus.imem_rdata};
          state_reg <= RUN;
        end
`endif
        default: state_reg <= BOOT_HI;
      endcase
    end
  end

  assign bus.pc             = pc_reg;
  assign bus.next_inst_addr = pc_reg + 32'd1;

  always_comb begin
    bus.imem_addr = pc_reg;
    bus.fd_enable = 1'b0;
    bus.opcode    = 5'd0;
    bus.Rs        = 3'd0;
    bus.Rd        = 3'd0;
    bus.shmnt     = 5'd0;
    bus.int1      = 1'b0;
    bus.int2      = 1'b0;
    case (state_reg)
      BOOT_HI: bus.imem_addr = RESET_VEC_ADDR;
      BOOT_LO: bus.imem_addr = RESET_VEC_ADDR + 32'd1;
      RUN: begin
        // Interrupt entry suppresses the current slot; the PC is kept as return address.
        bus.fd_enable = bus.branch_taken || (!bus.stall && !take_int);
        bus.opcode    = bus.imem_rdata[15:11];
        bus.Rs        = bus.imem_rdata[10:8];
        bus.Rd        = bus.imem_rdata[7:5];
        bus.shmnt     = bus.imem_rdata[4:0];
      end
`ifdef FETCH_INTERRUPT_EN
      INT1: begin
        bus.imem_addr = INT_VEC_ADDR;
        bus.fd_enable = 1'b1;
        bus.int1      = 1'b1;
      end
      INT2: begin
        bus.imem_addr = INT_VEC_ADDR + 32'd1;
        bus.fd_enable = 1'b1;
        bus.int2      = 1'b1;
      end
`endif
      default: bus.imem_addr = RESET_VEC_ADDR;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed boot/stall/branch/interrupt/reset
// scenarios plus a randomized run against a cycle-level reference model.
module tb_fetch_unit;

`ifdef FETCH_INTERRUPT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  logic [15:0] mem [0:1023];
  assign bus.imem_rdata = mem[bus.imem_addr[9:0]];

  fetch_unit #(.RESET_VEC_ADDR(32'd0), .INT_VEC_ADDR(32'd2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic init_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    mem[0]    = 16'h0000;
    mem[1]    = 16'h0010;
    mem[2]    = 16'h0000;
    mem[3]    = 16'h0080;
    mem[16]   = 16'hA9E3;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 32'd0; bus.int_req = 1'b0;
    #3;
    tests_run++;
    if (bus.fd_enable !== 1'b0) begin tests_failed++; $display("FAIL reset_fd_enable got %0b want 0", bus.fd_enable); end
    tests_run++;
    if (bus.pc !== 32'd0 || bus.next_inst_addr !== 32'd1) begin
      tests_failed++; $display("FAIL reset_pc got pc=%h next=%h want 0/1", bus.pc, bus.next_inst_addr);
    end
    tests_run++;
    if (bus.imem_addr !== 32'd0 || {bus.opcode, bus.Rs, bus.Rd, bus.shmnt} !== 16'd0 || {bus.int1, bus.int2} !== 2'b00) begin
      tests_failed++; $display("FAIL reset_outputs got addr=%h fields=%h ints=%b want 0/0/00",
        bus.imem_addr, {bus.opcode, bus.Rs, bus.Rd, bus.shmnt}, {bus.int1, bus.int2});
    end
    $display("[TB] test_reset done");
    step();
  endtask

  task automatic test_boot();
    rst_n = 1'b1;
    #2;
    tests_run++;
    if (bus.fd_enable !== 1'b0 || bus.imem_addr !== 32'd0) begin
      tests_failed++; $display("FAIL boot_hi got fd=%0b addr=%h want 0/0", bus.fd_enable, bus.imem_addr);
    end
    step(); #2;
    tests_run++;
    if (bus.fd_enable !== 1'b0 || bus.imem_addr !== 32'd1 || bus.opcode !== 5'd0) begin
      tests_failed++; $display("FAIL boot_lo got fd=%0b addr=%h op=%h want 0/1/0", bus.fd_enable, bus.imem_addr, bus.opcode);
    end
    step(); #2;
    tests_run++;
    if (bus.pc !== 32'h10 || bus.next_inst_addr !== 32'h11 || bus.fd_enable !== 1'b1) begin
      tests_failed++; $display("FAIL boot_first_pc got pc=%h next=%h fd=%0b want 10/11/1", bus.pc, bus.next_inst_addr, bus.fd_enable);
    end
    tests_run++;
    if (bus.opcode !== 5'h15 || bus.Rs !== 3'd1 || bus.Rd !== 3'd7 || bus.shmnt !== 5'd3) begin
      tests_failed++; $display("FAIL slice_fields got op=%h rs=%0d rd=%0d sh=%0d want 15/1/7/3", bus.opcode, bus.Rs, bus.Rd, bus.shmnt);
    end
    $display("[TB] test_boot done");
  endtask

  task automatic test_sequential();
    step(); #2;
    tests_run++;
    if (bus.pc !== 32'h11 || bus.imem_addr !== 32'h11) begin
      tests_failed++; $display("FAIL sequential got pc=%h addr=%h want 11/11", bus.pc, bus.imem_addr);
    end
    $display("[TB] test_sequential done");
  endtask

  task automatic test_stall();
    step();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      tests_run++;
      if (bus.pc !== 32'h12 || bus.fd_enable !== 1'b0) begin
        tests_failed++; $display("FAIL stall_hold[%0d] got pc=%h fd=%0b want 12/0", i, bus.pc, bus.fd_enable);
      end
      step();
    end
    bus.stall = 1'b0;
    #2;
    tests_run++;
    if (bus.pc !== 32'h12 || bus.fd_enable !== 1'b1) begin
      tests_failed++; $display("FAIL stall_release got pc=%h fd=%0b want 12/1", bus.pc, bus.fd_enable);
    end
    step(); #2;
    tests_run++;
    if (bus.pc !== 32'h13) begin tests_failed++; $display("FAIL stall_resume got pc=%h want 13", bus.pc); end
    $display("[TB] test_stall done");
  endtask

  task automatic test_branch_over_stall();
    bus.stall = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 32'h40;
    #2;
    tests_run++;
    if (bus.fd_enable !== 1'b1) begin tests_failed++; $display("FAIL branch_fd got %0b want 1", bus.fd_enable); end
    step();
    bus.stall = 1'b0; bus.branch_taken = 1'b0;
    #2;
    tests_run++;
    if (bus.pc !== 32'h40 || bus.fd_enable !== 1'b1) begin
      tests_failed++; $display("FAIL branch_target got pc=%h fd=%0b want 40/1", bus.pc, bus.fd_enable);
    end
    $display("[TB] test_branch_over_stall done");
  endtask

  task automatic test_interrupt();
    bus.branch_taken = 1'b1; bus.branch_target = 32'h20;
    step();
    bus.branch_taken = 1'b0;
    bus.int_req = 1'b1;
    #2;
`ifdef FETCH_INTERRUPT_EN
    tests_run++;
    if (bus.fd_enable !== 1'b0 || bus.pc !== 32'h20) begin
      tests_failed++; $display("FAIL int_entry_slot got fd=%0b pc=%h want 0/20", bus.fd_enable, bus.pc);
    end
    step(); bus.int_req = 1'b0; #2;
    tests_run++;
    if (bus.int1 !== 1'b1 || bus.int2 !== 1'b0 || bus.pc !== 32'h20 || bus.opcode !== 5'd0 ||
        bus.imem_addr !== 32'd2 || bus.fd_enable !== 1'b1) begin
      tests_failed++; $display("FAIL int1 got int1=%0b int2=%0b pc=%h op=%h addr=%h fd=%0b want 1/0/20/0/2/1",
        bus.int1, bus.int2, bus.pc, bus.opcode, bus.imem_addr, bus.fd_enable);
    end
    step(); #2;
    tests_run++;
    if (bus.int2 !== 1'b1 || bus.int1 !== 1'b0 || bus.pc !== 32'h20 || bus.imem_addr !== 32'd3 || bus.Rs !== 3'd0) begin
      tests_failed++; $display("FAIL int2 got int1=%0b int2=%0b pc=%h addr=%h rs=%0d want 0/1/20/3/0",
        bus.int1, bus.int2, bus.pc, bus.imem_addr, bus.Rs);
    end
    step(); #2;
    tests_run++;
    if (bus.pc !== 32'h80 || {bus.int1, bus.int2} !== 2'b00) begin
      tests_failed++; $display("FAIL int_vector got pc=%h ints=%b want 80/00", bus.pc, {bus.int1, bus.int2});
    end
`else
    tests_run++;
    if (bus.fd_enable !== 1'b1) begin tests_failed++; $display("FAIL noint_slot got fd=%0b want 1", bus.fd_enable); end
    step(); bus.int_req = 1'b0; #2;
    tests_run++;
    if (bus.pc !== 32'h21 || {bus.int1, bus.int2} !== 2'b00) begin
      tests_failed++; $display("FAIL noint_ignored got pc=%h ints=%b want 21/00", bus.pc, {bus.int1, bus.int2});
    end
`endif
    $display("[TB] test_interrupt done");
  endtask

  task automatic test_reset_mid_flight();
`ifdef FETCH_INTERRUPT_EN
    bus.int_req = 1'b1;
    step();
    bus.int_req = 1'b0;
    #1;
    tests_run++;
    if (bus.int1 !== 1'b1) begin tests_failed++; $display("FAIL mid_int_enter got int1=%0b want 1", bus.int1); end
`endif
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.int1, bus.int2} !== 2'b00 || bus.pc !== 32'd0 || bus.imem_addr !== 32'd0 || bus.fd_enable !== 1'b0) begin
      tests_failed++; $display("FAIL reset_abort got ints=%b pc=%h addr=%h fd=%0b want 00/0/0/0",
        {bus.int1, bus.int2}, bus.pc, bus.imem_addr, bus.fd_enable);
    end
    step();
    rst_n = 1'b1;
    step();
    // Abort mid-boot as well: reset during BOOT_LO must return to BOOT_HI at once.
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.imem_addr !== 32'd0) begin tests_failed++; $display("FAIL reset_mid_boot got addr=%h want 0", bus.imem_addr); end
    step();
    rst_n = 1'b1;
    step(); step(); #2;
    tests_run++;
    if (bus.pc !== 32'h10) begin tests_failed++; $display("FAIL reboot_pc got pc=%h want 10", bus.pc); end
    step(); #2;
    tests_run++;
    if (bus.pc !== 32'h11 || {bus.int1, bus.int2} !== 2'b00) begin
      tests_failed++; $display("FAIL pending_cleared got pc=%h ints=%b want 11/00", bus.pc, {bus.int1, bus.int2});
    end
    $display("[TB] test_reset_mid_flight done");
  endtask

  // Reference model: boot countdown, interrupt phase counter, program counter.
  task automatic test_random();
    int          boot_left = 2;
    int          int_phase = 0;
    bit          pend = 1'b0;
    logic [31:0] m_pc = 32'd0;
    logic [114:0] exp_v, got_v;
    logic [15:0]  word;
    logic [31:0]  e_addr;
    bit           e_fd, go_int;
    rst_n = 1'b0;
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.int_req = 1'b0;
    #1;
    step();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.stall         = ($urandom_range(0, 3) == 0);
      bus.branch_taken  = ($urandom_range(0, 9) == 0);
      bus.branch_target = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFE + 32'($urandom_range(0, 1))
                                                     : 32'($urandom_range(4, 1023));
      bus.int_req       = ($urandom_range(0, 19) == 0);
      #2;
      word   = 16'd0;
      e_fd   = 1'b0;
      go_int = 1'b0;
      if (boot_left > 0) e_addr = (boot_left == 2) ? 32'd0 : 32'd1;
      else if (int_phase != 0) begin
        e_addr = 32'd1 + 32'(int_phase);
        e_fd   = 1'b1;
      end else begin
        e_addr = m_pc;
        word   = mem[m_pc[9:0]];
        go_int = INT_EN && (pend || bus.int_req) && !bus.stall && !bus.branch_taken;
        e_fd   = bus.branch_taken || (!bus.stall && !go_int);
      end
      exp_v = {m_pc, m_pc + 32'd1, e_addr, e_fd, word, int_phase == 1, int_phase == 2};
      got_v = {bus.pc, bus.next_inst_addr, bus.imem_addr, bus.fd_enable,
               bus.opcode, bus.Rs, bus.Rd, bus.shmnt, bus.int1, bus.int2};
      tests_run++;
      if (got_v !== exp_v) begin
        tests_failed++; $display("FAIL random[%0d] got %h want %h", cyc, got_v, exp_v);
      end
      $display("[TB] rnd %0d st=%0b br=%0b irq=%0b pc=%h fd=%0b", cyc, bus.stall, bus.branch_taken,
               bus.int_req, bus.pc, bus.fd_enable);
      if (boot_left > 0) begin
        boot_left--;
        if (boot_left == 0) m_pc = {mem[0], mem[1]};
      end else if (int_phase == 1) int_phase = 2;
      else if (int_phase == 2) begin
        int_phase = 0;
        m_pc = {mem[2], mem[3]};
      end else if (bus.branch_taken) m_pc = bus.branch_target;
      else if (go_int) int_phase = 1;
      else if (!bus.stall) m_pc = m_pc + 32'd1;
      pend = INT_EN && !go_int && (pend || bus.int_req);
      step();
    end
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.int_req = 1'b0;
    $display("[TB] test_random done");
  endtask

  initial begin
    init_mem();
    test_reset();
    test_boot();
    test_sequential();
    test_stall();
    test_branch_over_stall();
    test_interrupt();
    test_reset_mid_flight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
